// File: rtl/mem_ctrl.sv
// Four-phase CPU-to-memory access controller (IDLE/SETUP/ACCESS/RELEASE), all outputs registered.
// Optional ACCESS timeout with cpu_err is built when MEM_TIMEOUT_EN is defined.
module mem_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
`ifdef MEM_TIMEOUT_EN
    output logic              cpu_err,
`endif
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_input_data,
    input  logic [DATA_W-1:0] mem_output_data,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

    state_t state;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
`endif

    // NOTE: state and every registered output use non-blocking assignments so all
    // of them update together on the edge, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data/address registers are plain flops, not a memory array,
            // so clearing them in reset is cheap and keeps the bus quiet after reset.
            state          <= IDLE;
            cpu_busy       <= 1'b0;
            cpu_done       <= 1'b0;
            cpu_rdata      <= '0;
            mem_en         <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_input_data <= '0;
`ifdef MEM_TIMEOUT_EN
            cpu_err        <= 1'b0;
            cnt            <= '0;
            timed_out      <= 1'b0;
`endif
        end else begin
            cpu_done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cpu_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_write      <= cpu_we;
                        mem_read       <= !cpu_we;
                        mem_address    <= cpu_addr;
                        mem_input_data <= cpu_wdata;
                        cpu_busy       <= 1'b1;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    mem_en <= 1'b1;
                    state  <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt       <= '0;
                    timed_out <= 1'b0;
`endif
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (mem_read) begin
                            cpu_rdata <= mem_output_data;
                        end
                        mem_en <= 1'b0;
                        state  <= RELEASE;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Give up on the TIMEOUT-th ACCESS cycle that still sees no ready.
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_en    <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!mem_ready) begin
                        cpu_done  <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_busy  <= 1'b0;
                        state     <= IDLE;
`ifdef MEM_TIMEOUT_EN
                        cpu_err   <= timed_out;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles to wait for mem_ready (MEM_TIMEOUT_EN only).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  1  access request; sampled only in IDLE.
REQ-007 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 cpu_addr  input  ADDR_W  access address; sampled with cpu_req.
REQ-009 cpu_wdata  input  DATA_W  write data; sampled with cpu_req.
REQ-010 cpu_busy  output  1  high whenever state is not IDLE.
REQ-011 cpu_done  output  1  one-cycle completion pulse.
REQ-012 cpu_rdata  output  DATA_W  last read data; holds until the next completed read.
REQ-013 cpu_err  output  1  timeout flag; valid while cpu_done is high; present only with MEM_TIMEOUT_EN.
REQ-014 mem_en, mem_read, mem_write  output  1 each  memory strobes.
REQ-015 mem_address  output  ADDR_W; mem_input_data  output  DATA_W  registered memory address and write data.
REQ-016 mem_output_data  input  DATA_W; mem_ready  input  1  memory read data and completion.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, ACCESS and RELEASE, with all outputs registered.
REQ-018 IDLE: cpu_req=1 SHALL latch cpu_we/cpu_addr/cpu_wdata into mem_write, mem_read (=!cpu_we), mem_address and mem_input_data, then go to SETUP; mem_en stays 0.
REQ-019 SETUP SHALL last exactly 1 cycle (strobes and address stable, mem_en=0), then go to ACCESS with mem_en=1.
REQ-020 ACCESS SHALL hold mem_en=1 and all strobes/address/data constant until mem_ready=1 is sampled.
REQ-021 On mem_ready=1 in ACCESS with a read, cpu_rdata SHALL capture mem_output_data on that edge; the FSM then enters RELEASE with mem_en=0.
REQ-022 RELEASE SHALL keep mem_en=0 and wait for mem_ready=0; on that edge it SHALL pulse cpu_done for 1 cycle, clear mem_read/mem_write and return to IDLE.
REQ-023 Minimum request-to-done latency SHALL be 4 cycles (IDLE->SETUP->ACCESS(ready)->RELEASE(ready low)->done).
REQ-024 cpu_req while cpu_busy=1 SHALL be ignored, not queued; a request held high SHALL be accepted again in the first IDLE cycle after cpu_done.
REQ-025 If mem_ready=1 is already high on ACCESS entry, it SHALL be accepted in the first ACCESS cycle.
REQ-026 A write SHALL never modify cpu_rdata.
REQ-027 mem_read and mem_write SHALL never be high simultaneously.

Reset
REQ-028 When rst_n=0 the block SHALL immediately, without waiting for clk, set state=IDLE, clear all outputs (cpu_rdata, mem_address and mem_input_data =0) and clear the timeout counter.
REQ-029 Reset asserted mid-ACCESS SHALL drop mem_en that same instant; no cpu_done SHALL follow for the aborted access.

Configuration
REQ-030 With macro MEM_TIMEOUT_EN defined, a counter SHALL run in ACCESS; if mem_ready is still 0 after TIMEOUT ACCESS cycles, the FSM SHALL go to RELEASE and cpu_done SHALL pulse with cpu_err=1, leaving cpu_rdata unchanged.
REQ-031 With MEM_TIMEOUT_EN undefined, the counter and the cpu_err port SHALL NOT exist, and ACCESS SHALL wait for mem_ready indefinitely.

Verification
REQ-032 Write: req, we=1, addr=7'd1, wdata=8'hFF, ready 1 cycle after en -> mem_write=1 and addr 1 stable for 1 cycle before mem_en=1; done pulses once; rdata unchanged.
REQ-033 Read: req, we=0, addr=7'd1, memory returns 8'hFF -> cpu_rdata=8'hFF on done; mem_read=1 throughout SETUP/ACCESS.
REQ-034 Busy reject: second req with addr=7'd5 during ACCESS -> mem_address stays 1; exactly one done.
REQ-035 Reset mid-ACCESS: rst_n low while mem_en=1 -> mem_en=0 and all outputs 0 immediately, no done, next req proceeds normally.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT=15, mem_ready tied 0 -> done with cpu_err=1 after 15 ACCESS cycles; without the macro the FSM stays in ACCESS after 100 cycles.
REQ-037 Ready already high on ACCESS entry -> accepted in the first ACCESS cycle; RELEASE holds until ready drops, then done.
